um_cfg_loader: RTL

//   Sequences the configuration of um_for_cpu over its 134-bit packet input.
//   On start it emits three packets: conf_sel=1 (hold CPU), a program-load packet

---
 rtl/um_cfg_loader.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/um_cfg_loader.sv
// Configuration sequencer for um_for_cpu: emits conf_sel=1, a ROM-streamed program packet, then conf_sel=0.
// Live words are forwarded 1 cycle late when idle; there is no backpressure, and live packets are dropped while configuring.
module um_cfg_loader #(
  parameter int PROG_WORDS = 10000,
  parameter int ADDR_W     = 16,
  parameter int GAP_CYCLES = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              pkt_in_valid,
  input  logic [133:0]      pkt_in_data,
  output logic              pkt_out_valid,
  output logic [133:0]      pkt_out_data,
  output logic              rom_rden,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_rdata,
  output logic [15:0]       drop_cnt
);

  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam int CW = (ADDR_W + 1 > GW) ? ADDR_W + 1 : GW;

  localparam logic [CW-1:0] LAST_SEL  = CW'(3);
  localparam logic [CW-1:0] LAST_GAP  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(PROG_WORDS - 1);

  localparam logic [127:0] WR_SEL   = 128'h1111_2222_3333_4444_5555_6666_9001_0000;
  localparam logic [127:0] WR_PROGM = 128'h1111_2222_3333_4444_5555_6666_9003_0000;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b00;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_SEL1,
    S_GAP1,
    S_PROG_HEAD,
    S_PROG_BODY,
    S_GAP2,
    S_SEL0,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_inc;
  logic [133:0]        out_q;
  logic                out_vld_q;
  logic                body_q;
  logic                busy_q;
  logic                done_q;
  logic                rden_q;
  logic [ADDR_W-1:0]   addr_q;

  logic                in_pkt_q, in_pkt_d;
  logic                drop_q, drop_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;

  logic [1:0]          in_tag;
  logic                live_head;
  logic                live_open;
  logic                live_end;
  logic                passthru;
  logic                fwd;
  logic                wait_exit;

  function automatic logic [133:0] sel_word(input logic [1:0] k, input logic conf);
    case (k)
      2'd0:    return {TAG_HEAD, 4'hf, WR_SEL};
      2'd1:    return {TAG_BODY, 4'hf, conf ? 128'h1_0000 : 128'h0};
      2'd2:    return {TAG_BODY, 4'hf, 128'h0};
      default: return {TAG_TAIL, 4'hf, 128'h0};
    endcase
  endfunction

  // ROM data is spliced in at the output mux, so the data field stays zero here.
  function automatic logic [133:0] body_word(input logic [CW-1:0] i);
    return {(i == LAST_WORD) ? TAG_TAIL : TAG_BODY, 4'hf, 48'h0, 32'h0, 16'h0, 16'(i), 16'h0};
  endfunction

  assign in_tag    = pkt_in_data[133:132];
  assign live_head = pkt_in_valid & in_tag[0];
  assign live_open = pkt_in_valid & (in_tag == TAG_HEAD);
  assign live_end  = pkt_in_valid & in_tag[1];
  assign passthru  = (state_q == S_IDLE) || (state_q == S_WAIT_IDLE);
  assign fwd       = pkt_in_valid & (~drop_q | live_head);
  assign wait_exit = (state_q == S_WAIT_IDLE) & ~in_pkt_q & ~live_head;
  assign cnt_inc   = cnt_q + CW'(1);

  // A packet opened outside pass-through stays dropped until its tail, even across DONE->IDLE.
  always_comb begin
    in_pkt_d   = in_pkt_q;
    drop_d     = drop_q;
    drop_cnt_d = drop_cnt_q;
    if (live_open) begin
      in_pkt_d = 1'b1;
      drop_d   = ~passthru;
    end else if (live_end) begin
      in_pkt_d = 1'b0;
      drop_d   = 1'b0;
    end
    if (live_head && !passthru && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_pkt_q   <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= 16'h0;
    end else begin
      in_pkt_q   <= in_pkt_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      body_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rden_q    <= 1'b0;
      addr_q    <= '0;
    end else begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
      body_q    <= 1'b0;
      done_q    <= 1'b0;
      rden_q    <= 1'b0;
      addr_q    <= '0;
      case (state_q)
        S_IDLE: begin
          out_vld_q <= fwd;
          out_q     <= fwd ? pkt_in_data : '0;
          if (start) begin
            state_q <= S_WAIT_IDLE;
            busy_q  <= 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (wait_exit) begin
            state_q   <= S_SEL1;
            cnt_q     <= '0;
            out_vld_q <= 1'b1;
            out_q     <= sel_word(2'd0, 1'b1);
          end else begin
            out_vld_q <= fwd;
            out_q     <= fwd ? pkt_in_data : '0;
          end
        end
        S_SEL1: begin
          if (cnt_q == LAST_SEL) begin
            state_q <= S_GAP1;
            cnt_q   <= '0;
          end else begin
            cnt_q     <= cnt_inc;
            out_vld_q <= 1'b1;
            out_q     <= sel_word(cnt_inc[1:0], 1'b1);
          end
        end
        S_GAP1: begin
          if (cnt_q == LAST_GAP) begin
            state_q   <= S_PROG_HEAD;
            out_vld_q <= 1'b1;
            out_q     <= {TAG_HEAD, 4'hf, WR_PROGM};
            rden_q    <= 1'b1;
            addr_q    <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_PROG_HEAD: begin
          state_q   <= S_PROG_BODY;
          cnt_q     <= '0;
          out_vld_q <= 1'b1;
          out_q     <= body_word('0);
          body_q    <= 1'b1;
          if (LAST_WORD != '0) begin
            rden_q <= 1'b1;
            addr_q <= ADDR_W'(1);
          end
        end
        S_PROG_BODY: begin
          if (cnt_q == LAST_WORD) begin
            state_q <= S_GAP2;
            cnt_q   <= '0;
          end else begin
            cnt_q     <= cnt_inc;
            out_vld_q <= 1'b1;
            out_q     <= body_word(cnt_inc);
            body_q    <= 1'b1;
            // Prefetch the word after the one going out next.
            if (cnt_inc != LAST_WORD) begin
              rden_q <= 1'b1;
              addr_q <= ADDR_W'(cnt_q + CW'(2));
            end
          end
        end
        S_GAP2: begin
          if (cnt_q == LAST_GAP) begin
            state_q   <= S_SEL0;
            cnt_q     <= '0;
            out_vld_q <= 1'b1;
            out_q     <= sel_word(2'd0, 1'b0);
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_SEL0: begin
          if (cnt_q == LAST_SEL) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q     <= cnt_inc;
            out_vld_q <= 1'b1;
            out_q     <= sel_word(cnt_inc[1:0], 1'b0);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pkt_out_valid = out_vld_q;
  assign pkt_out_data  = {out_q[133:80], body_q ? rom_rdata : out_q[79:48], out_q[47:0]};
  assign busy          = busy_q;
  assign done          = done_q;
  assign rom_rden      = rden_q;
  assign rom_addr      = addr_q;
  assign drop_cnt      = drop_cnt_q;

endmodule
